serial_deserializer: RTL and testbench
======================================

Name: serial_deserializer

Overview:
- Serial-to-parallel converter that collects single-bit samples into WIDTH-bit words.
- Sits directly upstream of the priority encoder: deser_data_o/deser_data_val_o drive its data_i/data_val_i.
- Supports partial-word flush with a length report.
- Registered outputs; one result pulse per completed or flushed word.

Parameters:
- WIDTH, 7, parallel word width (>=2).
- LEN_W, $clog2(WIDTH+1), width of deser_len_o (derived; not to be overridden).

Ports:
- clk_i  input  1  clock
- arstn_i  input  1  reset
- data_i  input  1  serial data bit
- data_val_i  input  1  data_i valid this cycle
- flush_i  input  1  emit pending partial word
- deser_data_o  output  WIDTH  assembled word, first-received bit at MSB
- deser_len_o  output  LEN_W  number of valid bits in deser_data_o (1..WIDTH)
- deser_data_val_o  output  1  one-cycle pulse, word/len valid

Behaviour:
- Interface: one clock, clk_i. Reset arstn_i is asynchronous and active-low.
- Reset values: shift register 0, bit counter 0, deser_data_o 0, deser_len_o 0, deser_data_val_o 0, state COLLECT.
- Reset mid-word discards partial bits. No output pulse follows reset.
- Ordering: MSB-first. The first bit received after a word boundary ends at bit WIDTH-1.
- Bit counter cnt runs 0..WIDTH-1 and advances only on data_val_i.
- With data_val_i low, shift register and cnt hold. Gaps of any length are allowed.
- Completion edge: the edge that samples data_val_i=1 with cnt==WIDTH-1 does all of the following:
  - loads deser_data_o with the full word;
  - loads deser_len_o with WIDTH;
  - sets deser_data_val_o=1 for exactly one cycle;
  - clears cnt to 0.
- Latency: output is visible the cycle after the last bit is presented.
- Back-to-back: a bit on the cycle right after completion is bit WIDTH-1 of the next word. No dead cycle.
- Flush:
  - flush_i=1 with cnt>0, or with data_val_i=1, emits a partial word.
  - The received bits are left-justified and the unused LSBs are 0.
  - deser_len_o = bits received, including any bit sampled the same cycle. cnt clears.
- Flush + completing bit in the same cycle: normal full word, len=WIDTH. Flush adds nothing.
- Flush with cnt==0 and data_val_i=0: no-op, no pulse.
- Between pulses, deser_data_o/deser_len_o hold their last value. deser_data_val_o is 0.
- State machine:
  - COLLECT only, without the optional feature.
  - COLLECT -> PARITY when the optional feature is compiled in (see below).

Optional Feature:
- Macro: SERIAL_DESERIALIZER_PARITY_EN.
- Defined:
  - After WIDTH data bits the FSM enters PARITY. The next valid bit is an even-parity bit.
  - The word is emitted on the parity-bit edge, with extra output parity_err_o (1 bit, reset 0).
  - parity_err_o = XOR of data bits and parity bit, valid with deser_data_val_o, held otherwise.
  - Flush in PARITY emits the word with len=WIDTH and parity_err_o=1, then returns to COLLECT.
  - Latency grows by one valid bit per word.
- Undefined:
  - No PARITY state and no parity_err_o port.
  - Behaviour exactly as above.

Decomposition:
- Package serial_deserializer_pkg:
  - state enum typedef (COLLECT, PARITY);
  - PARITY_EVEN localparam.
- Single module; no sub-module. Counter, shift register and FSM are small enough to stay inline.

Test Plan:
- WIDTH=7, bits 1,0,1,1,0,0,1 on consecutive cycles -> one cycle later deser_data_o=7'b1011001, len=7, val high exactly 1 cycle.
- Same bits with random data_val_i gaps of 0-5 cycles -> identical word/len; single pulse only after the 7th valid bit.
- Bits 1,1,0 then flush_i alone -> deser_data_o=7'b1100000, len=3. Then 7 more bits 0,1,0,1,0,1,0 -> 7'b0101010, len=7.
- 6 bits, then 7th bit with flush_i in the same cycle -> full word, len=7, one pulse. Flush with cnt==0 -> no pulse.
- 4 bits, arstn_i low mid-cycle (asynchronous) -> outputs immediately 0. After release, 7 bits 1,1,1,1,1,1,1 -> 7'b1111111, len=7; no leftover bits.
- With SERIAL_DESERIALIZER_PARITY_EN:
  - 1,0,1,1,0,0,1 + parity 0 -> word 7'b1011001, parity_err_o=0.
  - Same word + parity 1 -> parity_err_o=1.

Source files
------------

// File: rtl/serial_deserializer_pkg.sv
// Shared types and constants for the serial deserializer.
// The parity option is enabled by defining SERIAL_DESERIALIZER_PARITY_EN.
package serial_deserializer_pkg;

  // Collection state: PARITY is only reachable when the parity option is built in
  typedef enum logic {
    COLLECT = 1'b0,
    PARITY  = 1'b1
  } state_t;

  // XOR of all data bits plus the parity bit must equal this value for a clean word
  localparam logic PARITY_EVEN = 1'b0;

endpackage

// File: rtl/serial_deserializer.sv
// Serial-to-parallel converter: gathers single-bit samples MSB-first into
// WIDTH-bit words and supports flushing a partial word with a length report.
// Optional macro SERIAL_DESERIALIZER_PARITY_EN adds a trailing even-parity bit
// per word and a parity_err_o output.
module serial_deserializer
  import serial_deserializer_pkg::*;
#(
  parameter  int WIDTH = 7,
  localparam int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic             data_i,
  input  logic             data_val_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] deser_data_o,
  output logic [LEN_W-1:0] deser_len_o,
`ifdef SERIAL_DESERIALIZER_PARITY_EN
  output logic             parity_err_o,
`endif
  output logic             deser_data_val_o
);

  state_t            r_state;
  state_t            w_nextState;
  logic [WIDTH-1:0]  r_shift;
  logic [WIDTH-1:0]  w_shiftNext;
  logic [WIDTH-1:0]  w_word;
  logic [LEN_W-1:0]  r_cnt;
  logic [LEN_W-1:0]  w_cntNext;
  logic [WIDTH-1:0]  r_deserData;
  logic [LEN_W-1:0]  r_deserLen;
  logic              r_deserVal;
  logic              w_emit;
  logic [WIDTH-1:0]  w_emitWord;
  logic [LEN_W-1:0]  w_emitLen;
  logic              w_lastBit;
  logic              w_flushReq;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
  logic              r_parityErr;
  logic              w_emitErr;
`endif

  assign w_lastBit  = data_val_i && (r_cnt == LEN_W'(WIDTH - 1));
  assign w_flushReq = flush_i && ((r_cnt != '0) || data_val_i);

  // Word as it stands including this cycle's bit, kept left-justified so a flush needs no shifting
  always_comb begin
    w_word = r_shift;
    for (int i = 0; i < WIDTH; i++) begin
      if (data_val_i && (r_cnt == LEN_W'(WIDTH - 1 - i))) begin
        w_word[i] = data_i;
      end
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: a full word moves to PARITY only when the parity bit is expected
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      COLLECT: begin
`ifdef SERIAL_DESERIALIZER_PARITY_EN
        if (w_lastBit) begin
          w_nextState = PARITY;
        end
`endif
      end
`ifdef SERIAL_DESERIALIZER_PARITY_EN
      PARITY: begin
        if (data_val_i || flush_i) begin
          w_nextState = COLLECT;
        end
      end
`endif
      default: w_nextState = COLLECT;
    endcase
  end

  // Output/datapath decode: decides what the shift register, counter and result register do this edge
  always_comb begin
    w_shiftNext = r_shift;
    w_cntNext   = r_cnt;
    w_emit      = 1'b0;
    w_emitWord  = r_shift;
    w_emitLen   = r_cnt;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    w_emitErr   = 1'b0;
`endif
    case (r_state)
      COLLECT: begin
        if (w_lastBit) begin
`ifdef SERIAL_DESERIALIZER_PARITY_EN
          w_shiftNext = w_word;
          w_cntNext   = '0;
`else
          w_emit      = 1'b1;
          w_emitWord  = w_word;
          w_emitLen   = LEN_W'(WIDTH);
          w_shiftNext = '0;
          w_cntNext   = '0;
`endif
        end else if (w_flushReq) begin
          // A partial word carries no parity bit, so it never reports a parity error
          w_emit      = 1'b1;
          w_emitWord  = w_word;
          w_emitLen   = r_cnt + LEN_W'(data_val_i);
          w_shiftNext = '0;
          w_cntNext   = '0;
        end else if (data_val_i) begin
          w_shiftNext = w_word;
          w_cntNext   = r_cnt + LEN_W'(1);
        end
      end
`ifdef SERIAL_DESERIALIZER_PARITY_EN
      PARITY: begin
        if (data_val_i || flush_i) begin
          w_emit      = 1'b1;
          w_emitWord  = r_shift;
          w_emitLen   = LEN_W'(WIDTH);
          w_emitErr   = data_val_i ? ((^r_shift ^ data_i) != PARITY_EVEN) : 1'b1;
          w_shiftNext = '0;
          w_cntNext   = '0;
        end
      end
`endif
      default: ;
    endcase
  end

  // Shift register and bit counter; both hold while no valid bit arrives
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      r_shift <= w_shiftNext;
      r_cnt   <= w_cntNext;
    end
  end

  // Registered result: word/len held between pulses, valid pulses for one cycle
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_deserData <= '0;
      r_deserLen  <= '0;
      r_deserVal  <= 1'b0;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
      r_parityErr <= 1'b0;
`endif
    end else begin
      r_deserVal <= w_emit;
      if (w_emit) begin
        r_deserData <= w_emitWord;
        r_deserLen  <= w_emitLen;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
        r_parityErr <= w_emitErr;
`endif
      end
    end
  end

  assign deser_data_o     = r_deserData;
  assign deser_len_o      = r_deserLen;
  assign deser_data_val_o = r_deserVal;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
  assign parity_err_o     = r_parityErr;
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
// Scoreboard testbench for serial_deserializer (WIDTH=7). Expected words are
// queued as stimulus is issued; a monitor pops and compares on every pulse.
// Also covers SERIAL_DESERIALIZER_PARITY_EN when that macro is defined.
module tb_serial_deserializer;

  localparam int WIDTH = 7;
  localparam int LEN_W = 3;

  logic             clk_i      = 1'b0;
  logic             arstn_i    = 1'b0;
  logic             data_i     = 1'b0;
  logic             data_val_i = 1'b0;
  logic             flush_i    = 1'b0;
  logic [WIDTH-1:0] deser_data_o;
  logic [LEN_W-1:0] deser_len_o;
  logic             deser_data_val_o;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
  logic             parity_err_o;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [LEN_W-1:0] len;
    logic             err;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  serial_deserializer #(.WIDTH(WIDTH)) dut (
    .clk_i            (clk_i),
    .arstn_i          (arstn_i),
    .data_i           (data_i),
    .data_val_i       (data_val_i),
    .flush_i          (flush_i),
    .deser_data_o     (deser_data_o),
    .deser_len_o      (deser_len_o),
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    .parity_err_o     (parity_err_o),
`endif
    .deser_data_val_o (deser_data_val_o)
  );

  // Free-running clock
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input logic [WIDTH-1:0] data, input logic [LEN_W-1:0] len, input logic err);
    exp_t e;
    e.data = data;
    e.len  = len;
    e.err  = err;
    expQ.push_back(e);
  endtask

  // Monitor: every pulse must match the oldest queued expectation
  always @(negedge clk_i) begin
    if (arstn_i && deser_data_val_o === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedPulse actual=%0h expected=none", deser_data_o);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("word", 32'(deser_data_o), 32'(e.data));
        checkOutput("len", 32'(deser_len_o), 32'(e.len));
`ifdef SERIAL_DESERIALIZER_PARITY_EN
        checkOutput("parityErr", 32'(parity_err_o), 32'(e.err));
`endif
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic b, input logic f);
    data_val_i = v;
    data_i     = b;
    flush_i    = f;
    @(posedge clk_i);
    #1;
    data_val_i = 1'b0;
    data_i     = 1'b0;
    flush_i    = 1'b0;
  endtask

  task automatic idleGap(input int maxGap);
    int n;
    n = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic sendBits(input logic [WIDTH-1:0] bits, input int n, input int maxGap);
    for (int i = 0; i < n; i++) begin
      idleGap(maxGap);
      applyStimulus(1'b1, bits[WIDTH-1-i], 1'b0);
    end
  endtask

  // Full word; with the parity option the correct even-parity bit follows
  task automatic sendWord(input logic [WIDTH-1:0] word, input int maxGap);
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    sendBits(word, WIDTH, maxGap);
    pushExp(word, LEN_W'(WIDTH), 1'b0);
    idleGap(maxGap);
    applyStimulus(1'b1, ^word, 1'b0);
`else
    sendBits(word, WIDTH - 1, maxGap);
    pushExp(word, LEN_W'(WIDTH), 1'b0);
    idleGap(maxGap);
    applyStimulus(1'b1, word[0], 1'b0);
`endif
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("resetData", 32'(deser_data_o), 32'h0);
    checkOutput("resetLen", 32'(deser_len_o), 32'h0);
    checkOutput("resetVal", 32'(deser_data_val_o), 32'h0);
    @(negedge clk_i);
    arstn_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Consecutive bits, then hold check
    sendWord(7'b1011001, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("valLowAfterPulse", 32'(deser_data_val_o), 32'h0);
    checkOutput("dataHold", 32'(deser_data_o), 32'h59);
    checkOutput("lenHold", 32'(deser_len_o), 32'h7);

    // Same word with random gaps
    sendWord(7'b1011001, 5);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Partial flush, then a full word
    sendBits(7'b1100000, 3, 0);
    pushExp(7'b1100000, 3'd3, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    sendWord(7'b0101010, 0);

    // Flush together with a bit sampled the same cycle counts that bit
    sendBits(7'b1010000, 3, 0);
    pushExp(7'b1010000, 3'd4, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);

    // Completing bit with flush: ordinary full word
    sendBits(7'b1010101, 6, 0);
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    applyStimulus(1'b1, 1'b1, 1'b1);
    pushExp(7'b1010101, 3'd7, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
`else
    pushExp(7'b1010101, 3'd7, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
`endif
    // Flush with nothing pending is a no-op
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("noOpFlushVal", 32'(deser_data_val_o), 32'h0);
    checkOutput("noOpFlushHold", 32'(deser_data_o), 32'h55);

    // Asynchronous reset mid-word
    sendBits(7'b1011000, 4, 0);
    #2;
    arstn_i = 1'b0;
    #1;
    checkOutput("asyncRstData", 32'(deser_data_o), 32'h0);
    checkOutput("asyncRstLen", 32'(deser_len_o), 32'h0);
    checkOutput("asyncRstVal", 32'(deser_data_val_o), 32'h0);
    @(negedge clk_i);
    arstn_i = 1'b1;
    @(posedge clk_i);
    #1;
    sendWord(7'b1111111, 0);

`ifdef SERIAL_DESERIALIZER_PARITY_EN
    // Good parity, bad parity, flush while waiting for parity
    sendBits(7'b1011001, 7, 0);
    pushExp(7'b1011001, 3'd7, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    sendBits(7'b1011001, 7, 0);
    pushExp(7'b1011001, 3'd7, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    sendBits(7'b0110011, 7, 2);
    pushExp(7'b0110011, 3'd7, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
`endif

    // Drain and confirm every expected word appeared
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("queueEmpty", 32'(expQ.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
